// File: rtl/xif_copro_issue_ctrl.sv
// In-order issue/commit controller for an XIF coprocessor: buffers offloaded instructions
// until commit/kill, dispatches committed ones to the FU one at a time, and returns results.
module xif_copro_issue_ctrl #(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4,
    parameter int XLEN     = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [31:0]         issue_instr_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic                issue_rs1_valid_i,
    input  logic                pred_accept_i,
    output logic                issue_accept_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                ex_valid_o,
    input  logic                ex_ready_i,
    output logic [ID_WIDTH-1:0] ex_id_o,
    output logic [31:0]         ex_instr_o,
    output logic [XLEN-1:0]     ex_rs1_o,
    input  logic                fu_done_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic                result_we_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT_DONE,
        S_RESULT
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [DEPTH-1:0]    valid_vec, committed_vec, killed_vec;
    logic [ID_WIDTH-1:0] id_vec    [DEPTH];
    logic [31:0]         instr_vec [DEPTH];
    logic [XLEN-1:0]     rs1_vec   [DEPTH];

    logic                push, pop;
    logic                head_valid, head_committed, head_killed, head_commit_hit;
    logic [ID_WIDTH-1:0] head_id;
    logic [31:0]         head_instr;
    logic [XLEN-1:0]     head_rs1;

    assign issue_ready_o  = !rst_i && issue_rs1_valid_i && (count_q < DEPTH_C);
    assign issue_accept_o = pred_accept_i;
    assign push           = issue_valid_i && issue_ready_o && pred_accept_i;

    assign head_valid     = valid_vec[head_q];
    assign head_committed = committed_vec[head_q];
    assign head_killed    = killed_vec[head_q];
    assign head_id        = id_vec[head_q];
    assign head_instr     = instr_vec[head_q];
    assign head_rs1       = rs1_vec[head_q];

    // When the buffer is empty, the head slot is the one being written this cycle, so a
    // same-cycle commit is matched against the incoming id to dispatch without a bubble.
    assign head_commit_hit = commit_valid_i && !commit_kill_i &&
                             (commit_id_i == (head_valid ? head_id : issue_id_i));

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);

        logic                e_valid_q, e_committed_q, e_killed_q;
        logic [ID_WIDTH-1:0] e_id_q;
        logic [31:0]         e_instr_q;
        logic [XLEN-1:0]     e_rs1_q;
        logic                push_here, pop_here, cmt_here, new_hit;

        assign push_here = push && (tail_q == IDX);
        assign pop_here  = pop && (head_q == IDX);
        assign cmt_here  = commit_valid_i && e_valid_q && (e_id_q == commit_id_i);
        assign new_hit   = commit_valid_i && (commit_id_i == issue_id_i);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                e_valid_q     <= 1'b0;
                e_committed_q <= 1'b0;
                e_killed_q    <= 1'b0;
                e_id_q        <= '0;
                e_instr_q     <= '0;
                e_rs1_q       <= '0;
            end else if (push_here) begin
                e_valid_q     <= 1'b1;
                e_committed_q <= new_hit && !commit_kill_i;
                e_killed_q    <= new_hit && commit_kill_i;
                e_id_q        <= issue_id_i;
                e_instr_q     <= issue_instr_i;
                e_rs1_q       <= issue_rs1_i;
            end else if (pop_here) begin
                e_valid_q     <= 1'b0;
                e_committed_q <= 1'b0;
                e_killed_q    <= 1'b0;
            end else if (cmt_here) begin
                if (commit_kill_i) begin
                    e_killed_q <= 1'b1;
                end else begin
                    e_committed_q <= 1'b1;
                end
            end
        end

        assign valid_vec[gi]     = e_valid_q;
        assign committed_vec[gi] = e_committed_q;
        assign killed_vec[gi]    = e_killed_q;
        assign id_vec[gi]        = e_id_q;
        assign instr_vec[gi]     = e_instr_q;
        assign rs1_vec[gi]       = e_rs1_q;
    end

    // Kill state is only consulted in IDLE; once the head has left IDLE it runs to completion.
    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        ex_valid_o     = 1'b0;
        result_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (head_valid) begin
                    if (head_killed) begin
                        pop = 1'b1;
                    end else if (head_committed || head_commit_hit) begin
                        state_d = S_DISPATCH;
                    end
                end else if (push && head_commit_hit) begin
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                ex_valid_o = 1'b1;
                if (ex_ready_i) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (fu_done_i) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign ex_id_o     = ex_valid_o ? head_id : '0;
    assign ex_instr_o  = ex_valid_o ? head_instr : '0;
    assign ex_rs1_o    = ex_valid_o ? head_rs1 : '0;
    assign result_id_o = result_valid_o ? head_id : '0;
    assign result_we_o = 1'b0;

endmodule

// File: tb/tb_xif_copro_issue_ctrl.sv
// Scoreboard bench for xif_copro_issue_ctrl: directed issue/commit/kill sequences push expected
// dispatches and results; a negedge monitor pops and compares on every handshake.
module tb_xif_copro_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int IDW   = 4;
    localparam int XLEN  = 32;
    localparam logic [31:0] BITREV = 32'h6C00_502B;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            issue_valid_i, issue_ready_o;
    logic [IDW-1:0]  issue_id_i;
    logic [31:0]     issue_instr_i;
    logic [XLEN-1:0] issue_rs1_i;
    logic            issue_rs1_valid_i, pred_accept_i, issue_accept_o;
    logic            commit_valid_i, commit_kill_i;
    logic [IDW-1:0]  commit_id_i;
    logic            ex_valid_o, ex_ready_i;
    logic [IDW-1:0]  ex_id_o;
    logic [31:0]     ex_instr_o;
    logic [XLEN-1:0] ex_rs1_o;
    logic            fu_done_i;
    logic            result_valid_o, result_ready_i, result_we_o;
    logic [IDW-1:0]  result_id_o;

    always #5 clk = ~clk;

    xif_copro_issue_ctrl #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_id_i(issue_id_i), .issue_instr_i(issue_instr_i), .issue_rs1_i(issue_rs1_i),
        .issue_rs1_valid_i(issue_rs1_valid_i), .pred_accept_i(pred_accept_i),
        .issue_accept_o(issue_accept_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_id_o(ex_id_o),
        .ex_instr_o(ex_instr_o), .ex_rs1_o(ex_rs1_o), .fu_done_i(fu_done_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_we_o(result_we_o)
    );

    typedef struct {
        logic [IDW-1:0]  id;
        logic [31:0]     instr;
        logic [XLEN-1:0] rs1;
    } ex_t;

    ex_t            exp_ex[$];
    logic [IDW-1:0] exp_res[$];
    ex_t            mon_e;
    logic [IDW-1:0] mon_r;

    int checks = 0;
    int errors = 0;
    int fu_delay = 2;
    bit fu_lat_en = 1'b1;

    logic            prev_ex_hold = 1'b0, prev_res_hold = 1'b0, prev_fu = 1'b0;
    logic [IDW-1:0]  prev_ex_id = '0, prev_res_id = '0;
    logic [XLEN-1:0] prev_ex_rs1 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [IDW-1:0] id);
        return BITREV + {28'h0, id};
    endfunction

    // Functional unit model: completion pulse fu_delay cycles after each ex handshake.
    initial begin
        fu_done_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_i && ex_valid_o && ex_ready_i) begin
                @(posedge clk);
                repeat (fu_delay - 1) @(posedge clk);
                #1 fu_done_i = 1'b1;
                @(posedge clk);
                #1 fu_done_i = 1'b0;
            end
        end
    end

    // Monitor: scoreboard pops, hold-stability and done-to-result latency.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (prev_ex_hold) begin
                chk("ex_hold_valid", ex_valid_o, 1);
                chk("ex_hold_id", ex_id_o, prev_ex_id);
                chk("ex_hold_rs1", ex_rs1_o, prev_ex_rs1);
            end
            if (prev_res_hold) begin
                chk("res_hold_valid", result_valid_o, 1);
                chk("res_hold_id", result_id_o, prev_res_id);
            end
            if (prev_fu && fu_lat_en) chk("fu_done_to_result", result_valid_o, 1);
            if (ex_valid_o && ex_ready_i) begin
                if (exp_ex.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ex_unexpected actual id=%0d required no dispatch", ex_id_o);
                end else begin
                    mon_e = exp_ex.pop_front();
                    $display("ex     id=%0d instr=%08h rs1=%08h", ex_id_o, ex_instr_o, ex_rs1_o);
                    chk("ex_id", ex_id_o, mon_e.id);
                    chk("ex_instr", ex_instr_o, mon_e.instr);
                    chk("ex_rs1", ex_rs1_o, mon_e.rs1);
                end
            end
            if (result_valid_o && result_ready_i) begin
                if (exp_res.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL result_unexpected actual id=%0d required no result", result_id_o);
                end else begin
                    mon_r = exp_res.pop_front();
                    $display("result id=%0d we=%0d", result_id_o, result_we_o);
                    chk("result_id", result_id_o, mon_r);
                    chk("result_we", result_we_o, 0);
                end
            end
        end
        prev_ex_hold  = !rst_i && ex_valid_o && !ex_ready_i;
        prev_ex_id    = ex_id_o;
        prev_ex_rs1   = ex_rs1_o;
        prev_res_hold = !rst_i && result_valid_o && !result_ready_i;
        prev_res_id   = result_id_o;
        prev_fu       = !rst_i && fu_done_i;
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic issue(input logic [IDW-1:0] id, input logic [XLEN-1:0] rs1,
                         input bit acc, input bit cmt);
        int n;
        n = 0;
        issue_valid_i = 1'b1; issue_id_i = id; issue_instr_i = instr_of(id);
        issue_rs1_i = rs1; pred_accept_i = acc;
        commit_valid_i = cmt; commit_id_i = id; commit_kill_i = 1'b0;
        @(negedge clk);
        while (!issue_ready_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!issue_ready_o) begin
            checks++; errors++;
            $display("FAIL issue_ready_timeout actual=0 required=1 id=%0d", id);
        end
        chk("issue_accept", issue_accept_o, acc);
        @(posedge clk);
        #1;
        issue_valid_i = 1'b0; pred_accept_i = 1'b0; commit_valid_i = 1'b0;
    endtask

    task automatic send(input logic [IDW-1:0] id, input logic [XLEN-1:0] rs1,
                        input bit cmt, input bit exp_e, input bit exp_r);
        if (exp_e) exp_ex.push_back('{id, instr_of(id), rs1});
        if (exp_r) exp_res.push_back(id);
        issue(id, rs1, 1'b1, cmt);
    endtask

    task automatic commit(input logic [IDW-1:0] id, input bit kill);
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
        @(posedge clk);
        #1;
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_ex.size() != 0 || exp_res.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_ex.size() != 0 || exp_res.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual pending=%0d required=0", exp_ex.size() + exp_res.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_full(input string name, input logic [IDW-1:0] id);
        issue_valid_i = 1'b1; issue_id_i = id; pred_accept_i = 1'b1;
        @(negedge clk);
        chk(name, issue_ready_o, 0);
        @(posedge clk);
        #1;
        issue_valid_i = 1'b0; pred_accept_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        issue_valid_i = 1'b0; issue_id_i = '0; issue_instr_i = '0; issue_rs1_i = '0;
        issue_rs1_valid_i = 1'b1; pred_accept_i = 1'b0;
        commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
        ex_ready_i = 1'b1; result_ready_i = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_issue_ready", issue_ready_o, 0);
        chk("rst_ex_valid", ex_valid_o, 0);
        chk("rst_result_valid", result_valid_o, 0);
        chk("rst_ex_id", ex_id_o, 0);
        chk("rst_ex_instr", ex_instr_o, 0);
        chk("rst_ex_rs1", ex_rs1_o, 0);
        chk("rst_result_id", result_id_o, 0);
        chk("rst_result_we", result_we_o, 0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_issue_ready", issue_ready_o, 1);
        @(posedge clk);
        #1;

        // Single BITREV, same-cycle commit, with 3 cycles of ex backpressure
        ex_ready_i = 1'b0;
        send(4'd3, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("single_ex_latency", ex_valid_o, 1);
        chk("single_ex_id", ex_id_o, 3);
        chk("single_ex_rs1", ex_rs1_o, 32'h1);
        repeat (3) @(posedge clk);
        #1 ex_ready_i = 1'b1;
        drain();

        // Reject: nothing buffered, miss commit ignored
        issue(4'd7, 32'h7777_7777, 1'b0, 1'b0);
        commit(4'd7, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reject_no_ex", ex_valid_o, 0);
        end
        @(posedge clk);
        #1;

        // Ordering: commits in reverse order, uncommitted head blocks
        send(4'd1, 32'h11, 1'b0, 1'b1, 1'b1);
        send(4'd2, 32'h22, 1'b0, 1'b1, 1'b1);
        send(4'd3, 32'h33, 1'b0, 1'b1, 1'b1);
        commit(4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("order_blocked_a", ex_valid_o, 0);
        end
        @(posedge clk);
        #1;
        commit(4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("order_blocked_b", ex_valid_o, 0);
        end
        @(posedge clk);
        #1;
        commit(4'd1, 1'b0);
        @(negedge clk);
        chk("commit_to_ex", ex_valid_o, 1);
        drain();

        // Kill: id 4 killed, only id 5 executes
        send(4'd4, 32'h44, 1'b0, 1'b0, 1'b0);
        send(4'd5, 32'h55, 1'b0, 1'b1, 1'b1);
        commit(4'd4, 1'b1);
        commit(4'd5, 1'b0);
        drain();

        // Full and pointer wrap
        send(4'd6, 32'h66, 1'b0, 1'b1, 1'b1);
        send(4'd7, 32'h77, 1'b0, 1'b1, 1'b1);
        send(4'd8, 32'h88, 1'b0, 1'b1, 1'b1);
        send(4'd9, 32'h99, 1'b0, 1'b1, 1'b1);
        check_full("full_issue_ready", 4'd10);
        commit(4'd6, 1'b0);
        commit(4'd7, 1'b0);
        commit(4'd8, 1'b0);
        commit(4'd9, 1'b0);
        drain();
        for (int i = 10; i < 14; i++) begin
            send(IDW'(i), 32'hA000_0000 + 32'(i), 1'b1, 1'b1, 1'b1);
        end
        drain();

        // Result backpressure
        result_ready_i = 1'b0;
        send(4'd14, 32'hE, 1'b1, 1'b1, 1'b1);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!result_valid_o && n < 50) begin
                n++;
                @(negedge clk);
            end
            chk("bp_result_seen", result_valid_o, 1);
        end
        repeat (5) @(posedge clk);
        #1 result_ready_i = 1'b1;
        drain();

        // Reset while in WAIT_DONE: no result, buffer empty afterwards
        fu_lat_en = 1'b0;
        fu_delay = 10;
        send(4'd15, 32'hF, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        exp_res.delete();
        @(negedge clk);
        chk("rst_mid_ex_valid", ex_valid_o, 0);
        chk("rst_mid_result_valid", result_valid_o, 0);
        chk("rst_mid_issue_ready", issue_ready_o, 1);
        @(posedge clk);
        #1;
        send(4'd1, 32'h1, 1'b0, 1'b0, 1'b0);
        send(4'd2, 32'h2, 1'b0, 1'b0, 1'b0);
        send(4'd3, 32'h3, 1'b0, 1'b0, 1'b0);
        send(4'd4, 32'h4, 1'b0, 1'b0, 1'b0);
        check_full("refill_full", 4'd5);
        commit(4'd1, 1'b1);
        commit(4'd2, 1'b1);
        commit(4'd3, 1'b1);
        commit(4'd4, 1'b1);
        repeat (15) @(posedge clk);
        #1;
        fu_lat_en = 1'b1;
        fu_delay = 2;
        send(4'd2, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        drain();

        chk("final_ex_queue_empty", exp_ex.size(), 0);
        chk("final_res_queue_empty", exp_res.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xif_copro_issue_ctrl.md
# xif_copro_issue_ctrl

In-order issue/commit controller for the XIF coprocessor. Buffers accepted offloaded instructions (e.g. BITREV) with their rs1 operand until the core commits or kills them. Dispatches committed instructions one at a time to the coprocessor execution unit. Returns one XIF result per executed instruction. Sits between the core's XIF issue/commit/result channels and the functional unit, with the instruction predecoder supplying the accept decision.

## Interface
- DEPTH, 4: in-flight buffer entries (power of two, ≥2)
- ID_WIDTH, 4: XIF instruction id width
- XLEN, 32: operand width
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- issue_valid_i  in  1  XIF issue request
- issue_ready_o  out  1  issue handshake ready
- issue_id_i  in  ID_WIDTH  instruction id
- issue_instr_i  in  32  instruction word
- issue_rs1_i  in  XLEN  rs1 value
- issue_rs1_valid_i  in  1  rs1 value valid
- pred_accept_i  in  1  predecoder accept for issue_instr_i (combinational)
- issue_accept_o  out  1  accept response, = pred_accept_i
- commit_valid_i  in  1  commit event
- commit_id_i  in  ID_WIDTH  committed/killed id
- commit_kill_i  in  1  1 = kill, 0 = commit
- ex_valid_o  out  1  dispatch to FU
- ex_ready_i  in  1  FU accepts dispatch
- ex_id_o  out  ID_WIDTH  dispatched id
- ex_instr_o  out  32  dispatched instruction
- ex_rs1_o  out  XLEN  dispatched operand
- fu_done_i  in  1  FU completion pulse for the dispatched instruction
- result_valid_o  out  1  XIF result
- result_ready_i  in  1  core accepts result
- result_id_o  out  ID_WIDTH  result id
- result_we_o  out  1  register writeback; constant 0

## Operation
- Buffer: circular FIFO of DEPTH entries {id, instr, rs1, committed, killed}, with head/tail pointers and a count.
- issue_ready_o = issue_rs1_valid_i && (count < DEPTH). Count is registered; no same-cycle pop bypass.
- An issue handshake (valid && ready) with pred_accept_i=1 pushes an entry with committed=0 and killed=0.
  - With pred_accept_i=0 nothing is pushed.
- commit_valid_i: search all valid entries for commit_id_i and set committed, or killed if commit_kill_i=1.
  - Also matches an entry pushed in the same cycle.
  - A miss is ignored.
  - In-flight ids are unique (core guarantee).
- FSM states IDLE, DISPATCH, WAIT_DONE, RESULT:
  - IDLE: if head is valid and killed, pop it (no FU activity, no result) and stay in IDLE. If head is valid, committed and not killed, go to DISPATCH.
  - DISPATCH: ex_valid_o=1 with head fields. Hold until ex_ready_i, then go to WAIT_DONE.
  - WAIT_DONE: on fu_done_i, go to RESULT.
  - RESULT: result_valid_o=1, result_id_o=head id. On result_ready_i, pop head and go to IDLE.
- A kill arriving for the head after it has left IDLE is ignored. The instruction completes normally.
- Strictly in order: an uncommitted head blocks later committed entries.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.

## Timing
- Reset: issue_ready_o=0 while rst_i is high, ex_valid_o=0, result_valid_o=0, outputs ex_*/result_id_o=0, count=0, state IDLE, all entries invalid.
- Reset mid-operation discards all entries and returns to IDLE the next cycle. No result is emitted.
- Issue handshake and commit in cycle t with an empty buffer: ex_valid_o=1 in cycle t+1.
- ex handshake in cycle e: WAIT_DONE in e+1. fu_done_i is honoured from e+1 onward.
- fu_done_i in cycle d: result_valid_o=1 in d+1.
- Result handshake in cycle r: pop at r+1. Next ex_valid_o no earlier than r+2.
- Killed head: popped one cycle after reaching IDLE with killed=1.
- ex_* and result_* are stable while valid is high and ready is low.
- Simultaneous push and pop: count unchanged, both pointers advance.

## Test plan
- Single BITREV: issue id=3 with rs1=0x0000_0001 and commit id=3 in the same cycle. Expect ex_valid_o the next cycle with ex_rs1_o=0x1. fu_done_i 2 cycles after ex handshake. Expect result_id_o=3, result_we_o=0, one cycle after fu_done_i.
- Reject: issue with pred_accept_i=0. Expect issue_accept_o=0, count unchanged, no ex_valid_o for 10 cycles.
- Ordering/blocking: issue ids 1,2,3; commit 3, then 2, then 1. Expect dispatch order 1,2,3 with no dispatch before commit of id 1.
- Kill: issue ids 4,5; kill 4; commit 5. Expect no ex/result for id 4, and the id 5 result only.
- Full/wrap: with DEPTH=4, issue 4 without commits. Expect issue_ready_o=0. Commit all, drain, then issue 4 more. Expect correct ids across pointer wrap.
- Backpressure and reset: hold result_ready_i=0 for 5 cycles and check result_* is stable. Then assert rst_i in WAIT_DONE. Expect all valids 0 and count=0 the next cycle.
